rv32_shift_issue: RTL and testbench



---
 rtl/rv32_shift_issue.sv | 93 +++++++++
 tb/tb_rv32_shift_issue.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/rv32_shift_issue.sv
// rv32_shift_issue: legality check, one-cycle issue and writeback handshake
// for the RV32 shift unit (SLL/SRL/SRA and immediate forms).
module rv32_shift_issue #(
    parameter bit CHECK_FUNCT7 = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_rs1,
    input  logic [31:0] in_rs2,
    output logic        sh_enable,
    output logic        sh_logical,
    output logic        sh_direction,
    output logic        sh_immediate,
    output logic [31:0] sh_code_bus,
    output logic [31:0] sh_rs1,
    output logic [31:0] sh_rs2,
    input  logic [31:0] sh_result,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        illegal
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    state_t state_q, state_d;
    logic [6:0] opcode, funct7;
    logic [2:0] funct3;
    logic right, legal, accept;
    logic sh_enable_q, sh_logical_q, sh_direction_q, sh_immediate_q, illegal_q;
    logic [31:0] sh_code_q, sh_rs1_q, sh_rs2_q;

    assign opcode = in_instr[6:0];
    assign funct3 = in_instr[14:12];
    assign funct7 = in_instr[31:25];
    assign right  = funct3 == 3'b101;
    // 0100000 is only meaningful as the arithmetic-right selector
    assign legal  = (opcode == 7'b0010011 || opcode == 7'b0110011)
                 && (funct3 == 3'b001 || right)
                 && (!CHECK_FUNCT7 || funct7 == 7'b0000000 || (right && funct7 == 7'b0100000));
    assign accept = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            sh_enable_q    <= 1'b0;
            illegal_q      <= 1'b0;
            sh_logical_q   <= 1'b0;
            sh_direction_q <= 1'b0;
            sh_immediate_q <= 1'b0;
            sh_code_q      <= 32'd0;
            sh_rs1_q       <= 32'd0;
            sh_rs2_q       <= 32'd0;
        end else begin
            state_q     <= state_d;
            sh_enable_q <= accept && legal;
            illegal_q   <= accept && !legal;
            if (accept && legal) begin
                sh_logical_q   <= right && !in_instr[30];
                sh_direction_q <= right;
                sh_immediate_q <= opcode == 7'b0010011;
                sh_code_q      <= in_instr;
                sh_rs1_q       <= in_rs1;
                sh_rs2_q       <= in_rs2 & 32'h0000_001F;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        in_ready = state_q == IDLE;
        wb_valid = state_q == RESP;
        wb_rd    = wb_valid ? sh_code_q[11:7] : 5'd0;
        wb_data  = wb_valid ? sh_result : 32'd0;
        case (state_q)
            IDLE:    state_d = (accept && legal) ? EXEC : IDLE;
            EXEC:    state_d = (sh_code_q[11:7] != 5'd0) ? RESP : IDLE;
            RESP:    state_d = wb_ready ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
    end

    assign sh_enable    = sh_enable_q;
    assign illegal      = illegal_q;
    assign sh_logical   = sh_logical_q;
    assign sh_direction = sh_direction_q;
    assign sh_immediate = sh_immediate_q;
    assign sh_code_bus  = sh_code_q;
    assign sh_rs1       = sh_rs1_q;
    assign sh_rs2       = sh_rs2_q;
endmodule

// File: tb/tb_rv32_shift_issue.sv
// tb_rv32_shift_issue: directed and random shifts against a reference model,
// with a behavioural one-cycle barrel shifter closing the loop.
module tb_rv32_shift_issue;
    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, wb_ready;
    logic [31:0] in_instr, in_rs1, in_rs2;
    logic        sh_enable, sh_logical, sh_direction, sh_immediate;
    logic [31:0] sh_code_bus, sh_rs1, sh_rs2;
    logic [31:0] sh_result = 32'd0;
    logic        wb_valid, illegal;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data, last_wb;
    logic [4:0]  sh_amt;
    logic signed [31:0] sra_v;
    int n_checks = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    rv32_shift_issue #(.CHECK_FUNCT7(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .sh_enable(sh_enable), .sh_logical(sh_logical), .sh_direction(sh_direction),
        .sh_immediate(sh_immediate), .sh_code_bus(sh_code_bus), .sh_rs1(sh_rs1),
        .sh_rs2(sh_rs2), .sh_result(sh_result), .wb_valid(wb_valid),
        .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data), .illegal(illegal)
    );

    assign sh_amt = sh_immediate ? sh_code_bus[24:20] : sh_rs2[4:0];
    assign sra_v  = $signed(sh_rs1) >>> sh_amt;

    always_ff @(posedge clk)
        if (sh_enable)
            sh_result <= sh_direction ? (sh_logical ? sh_rs1 >> sh_amt : sra_v) : sh_rs1 << sh_amt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic bit ref_legal(input logic [31:0] w);
        bit op_ok = w[6:0] == 7'h13 || w[6:0] == 7'h33;
        bit f3_ok = w[14:12] == 3'd1 || w[14:12] == 3'd5;
        bit f7_ok = w[31:25] == 7'h00 || (w[31:25] == 7'h20 && w[14:12] == 3'd5);
        return op_ok && f3_ok && f7_ok;
    endfunction

    function automatic logic [31:0] ref_shift(input logic [31:0] w, input logic [31:0] a, input logic [31:0] b);
        int amt = (w[6:0] == 7'h33) ? int'(b % 32) : int'(w[24:20]);
        logic [31:0] fill = a[31] ? ~(32'hFFFF_FFFF >> amt) : 32'd0;
        if (w[14:12] == 3'd1) return a << amt;
        return w[30] ? ((a >> amt) | fill) : (a >> amt);
    endfunction

    task automatic run(input logic [31:0] w, input logic [31:0] a, input logic [31:0] b,
                       input int stall, input logic [31:0] nxt);
        bit legal = ref_legal(w);
        logic [4:0] rd = w[11:7];
        logic [31:0] res = ref_shift(w, a, b);
        check("idle_ready", in_ready, 1);
        in_valid = 1'b1; in_instr = w; in_rs1 = a; in_rs2 = b; wb_ready = 1'b0;
        @(negedge clk);
        in_valid = nxt != 32'd0;
        if (nxt != 32'd0) in_instr = nxt;
        if (!legal) begin
            check("illegal_pulse", illegal, 1);
            check("illegal_no_en", sh_enable, 0);
            check("illegal_no_wb", wb_valid, 0);
            @(negedge clk);
            check("illegal_once", illegal, 0);
            check("illegal_no_en2", sh_enable, 0);
            check("illegal_idle", in_ready, 1);
            return;
        end
        check("en", sh_enable, 1);
        check("no_illegal", illegal, 0);
        check("exec_busy", in_ready, 0);
        check("dir", sh_direction, w[14:12] == 3'd5);
        check("logical", sh_logical, w[14:12] == 3'd5 && !w[30]);
        check("imm", sh_immediate, w[6:0] == 7'h13);
        check("rs1", sh_rs1, a);
        check("rs2", sh_rs2, b % 32);
        check("code", sh_code_bus, w);
        @(negedge clk);
        check("en_pulse", sh_enable, 0);
        if (rd == 5'd0) begin
            check("x0_no_wb", wb_valid, 0);
            check("x0_idle", in_ready, 1);
            return;
        end
        for (int i = 0; i <= stall; i++) begin
            wb_ready = i == stall;
            check("wb_valid", wb_valid, 1);
            check("wb_rd", wb_rd, rd);
            check("wb_data", wb_data, res);
            check("resp_busy", in_ready, 0);
            check("code_hold", sh_code_bus, w);
            last_wb = wb_data;
            @(negedge clk);
        end
        wb_ready = 1'b0;
        check("wb_done", wb_valid, 0);
        check("resp_idle", in_ready, 1);
    endtask

    initial begin
        logic [31:0] w;
        rst_n = 1'b0; in_valid = 1'b0; wb_ready = 1'b0;
        in_instr = 32'd0; in_rs1 = 32'd0; in_rs2 = 32'd0; last_wb = 32'd0;
        repeat (2) @(negedge clk);
        check("rst_ready", in_ready, 1);
        check("rst_en", sh_enable, 0);
        check("rst_ill", illegal, 0);
        check("rst_wbv", wb_valid, 0);
        check("rst_rd", wb_rd, 0);
        check("rst_data", wb_data, 0);
        check("rst_code", sh_code_bus, 0);
        check("rst_rs1", sh_rs1, 0);
        check("rst_rs2", sh_rs2, 0);
        check("rst_ctl", {sh_logical, sh_direction, sh_immediate}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        run(32'h0040_9293, 32'h0000_00F1, 32'h0, 0, 32'h0);
        check("slli_data", last_wb, 32'h0000_0F10);
        run(32'h4041_51B3, 32'h8000_0000, 32'h0000_0024, 0, 32'h0);
        check("sra_data", last_wb, 32'hF800_0000);
        run(32'h01F3_5393, 32'h8000_0000, 32'h0, 0, 32'h0);
        check("srli_data", last_wb, 32'h0000_0001);
        run(32'h0040_9293, 32'h0000_00F1, 32'h0, 3, 32'h4041_51B3);
        check("stall_data", last_wb, 32'h0000_0F10);
        run(32'h4041_51B3, 32'h8000_0000, 32'h0000_0024, 0, 32'h0);
        check("after_stall_data", last_wb, 32'hF800_0000);
        run(32'h0010_0093, 32'h1, 32'h2, 0, 32'h0);
        run(32'h4040_9293, 32'h1, 32'h2, 0, 32'h0);
        run(32'h0040_9013, 32'h1, 32'h2, 0, 32'h0);

        in_valid = 1'b1; in_instr = 32'h0040_9293; in_rs1 = 32'hF1;
        @(negedge clk);
        in_valid = 1'b0;
        check("exec_en", sh_enable, 1);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_exec_en", sh_enable, 0);
        check("rst_exec_ready", in_ready, 1);
        rst_n = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check("resp_before_rst", wb_valid, 1);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_resp_wbv", wb_valid, 0);
        check("rst_resp_data", wb_data, 0);
        check("rst_resp_ready", in_ready, 1);
        rst_n = 1'b1;
        @(negedge clk);

        for (int n = 0; n < 60; n++) begin
            int r = $urandom_range(0, 9);
            w = $urandom;
            w[6:0]   = r == 0 ? 7'($urandom) : ($urandom_range(0, 1) != 0 ? 7'h13 : 7'h33);
            w[14:12] = r == 1 ? 3'($urandom) : ($urandom_range(0, 1) != 0 ? 3'd1 : 3'd5);
            w[31:25] = r == 2 ? 7'($urandom) : ($urandom_range(0, 1) != 0 ? 7'h00 : 7'h20);
            if (r == 3) w[11:7] = 5'd0;
            run(w, $urandom, $urandom, $urandom_range(0, 3), 32'h0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
